alb_seq: RTL and testbench

Parametrised, sequential successor to the 10-bit combinational ALB-plus-normalizer pair. It accepts one operation over a valid/ready handshake and computes one of four ALB functions with CO/VO/NO/ZO flags. It can optionally normalise the result with a one-bit-per-cycle left shifter that reports the shift count. A stored carry lets multi-word add/subtract chains run without external carry plumbing.

---
 rtl/alb_seq.sv | 134 +++++++++++++
 tb/tb_alb_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alb_seq.sv
// Sequential ALB with optional one-bit-per-cycle left normaliser and stored carry.
// One operation at a time over valid/ready; flags describe the raw result.
module alb_seq #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic             ci,
  input  logic             use_carry,
  input  logic [1:0]       sel,
  input  logic             norm_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             co,
  output logic             vo,
  output logic             no,
  output logic             zo
);

  typedef enum logic [1:0] {IDLE, EXEC, NORM, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] r_reg, s_reg, f_reg;
  logic [1:0]       sel_reg;
  logic             norm_reg, cin_reg, carry_q;
  logic [CNT_W-1:0] cnt_reg;
  logic             co_reg, vo_reg, no_reg, zo_reg;

  logic [WIDTH-1:0] op_b, raw_f, shl_f;
  logic [WIDTH:0]   sum;
  logic             raw_co, raw_vo;
  logic [CNT_W-1:0] shl_cnt;

  function automatic logic is_norm(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] c);
    return (v[WIDTH-1] != v[WIDTH-2]) || (v == '0) || (c == CNT_W'(WIDTH-1));
  endfunction

  // Subtract shares the adder: R + ~S + CI.
  always_comb begin
    op_b   = sel_reg[1] ? ~s_reg : s_reg;
    sum    = {1'b0, r_reg} + {1'b0, op_b} + (WIDTH+1)'(cin_reg);
    raw_f  = '0;
    raw_co = 1'b0;
    raw_vo = 1'b0;
    case (sel_reg)
      2'b00: raw_f = ~r_reg | s_reg;
      2'b10: raw_f = ~(r_reg ^ s_reg);
      default: begin
        raw_f  = sum[WIDTH-1:0];
        raw_co = sum[WIDTH];
        raw_vo = (r_reg[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != r_reg[WIDTH-1]);
      end
    endcase
  end

  assign shl_f   = {f_reg[WIDTH-2:0], 1'b0};
  assign shl_cnt = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = EXEC;
      EXEC: state_next = (norm_reg && !is_norm(raw_f, '0)) ? NORM : DONE;
      NORM: if (is_norm(shl_f, shl_cnt)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg    <= '0;
      s_reg    <= '0;
      sel_reg  <= '0;
      norm_reg <= 1'b0;
      cin_reg  <= 1'b0;
      carry_q  <= 1'b0;
      f_reg    <= '0;
      cnt_reg  <= '0;
      co_reg   <= 1'b0;
      vo_reg   <= 1'b0;
      no_reg   <= 1'b0;
      zo_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          r_reg    <= r;
          s_reg    <= s;
          sel_reg  <= sel;
          norm_reg <= norm_en;
          cin_reg  <= use_carry ? carry_q : ci;
        end
        EXEC: begin
          f_reg   <= raw_f;
          cnt_reg <= '0;
          co_reg  <= raw_co;
          vo_reg  <= raw_vo;
          no_reg  <= raw_f[WIDTH-1];
          zo_reg  <= (raw_f == '0);
          carry_q <= raw_co;
        end
        NORM: begin
          f_reg   <= shl_f;
          cnt_reg <= shl_cnt;
        end
        default: ;
      endcase
    end
  end

  // Reset forces the handshake pair to its idle values immediately.
  assign in_ready  = (state_reg == IDLE) || rst;
  assign out_valid = (state_reg == DONE) && !rst;
  assign f         = f_reg;
  assign shift_cnt = cnt_reg;
  assign co        = co_reg;
  assign vo        = vo_reg;
  assign no        = no_reg;
  assign zo        = zo_reg;

endmodule

// File: tb/tb_alb_seq.sv
// Scoreboard bench for alb_seq: driver pushes expected results, a negedge
// monitor compares every presented output, its latency and the handshake.
module tb_alb_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, ci, use_carry, norm_en, out_valid, out_ready;
  logic [9:0] r, s, f;
  logic [1:0] sel;
  logic [3:0] shift_cnt;
  logic       co, vo, no, zo;

  alb_seq #(.WIDTH(10), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .s(s), .ci(ci), .use_carry(use_carry), .sel(sel), .norm_en(norm_en),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .shift_cnt(shift_cnt),
    .co(co), .vo(vo), .no(no), .zo(zo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] f;
    logic [3:0] cnt;
    logic       co, vo, no, zo;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   txn = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out f=%b cnt=%0d, no result was pending", f, shift_cnt);
      end else begin
        mon_e = q[0];
        if (!seen) begin
          checks++;
          if (cyc - mon_e.acc != mon_e.lat) begin
            errors++;
            $display("FAIL latency got %0d cycles, expected %0d", cyc - mon_e.acc, mon_e.lat);
          end
          seen = 1'b1;
        end
        checks++;
        if ({f, shift_cnt, co, vo, no, zo} !== {mon_e.f, mon_e.cnt, mon_e.co, mon_e.vo, mon_e.no, mon_e.zo}) begin
          errors++;
          $display("FAIL result got f=%b cnt=%0d co=%b vo=%b no=%b zo=%b, expected f=%b cnt=%0d co=%b vo=%b no=%b zo=%b",
                   f, shift_cnt, co, vo, no, zo, mon_e.f, mon_e.cnt, mon_e.co, mon_e.vo, mon_e.no, mon_e.zo);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_valid in_ready=%b while out_valid=1, expected 0", in_ready);
        end
        if (out_ready) begin
          txn++;
          $display("txn %0d f=%b cnt=%0d co=%b vo=%b no=%b zo=%b", txn, f, shift_cnt, co, vo, no, zo);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [1:0] sl, input logic [9:0] rr, input logic [9:0] ss,
                       input logic c, input logic uc, input logic ne,
                       input logic [9:0] ef, input logic [3:0] ecnt,
                       input logic eco, input logic evo, input logic eno, input logic ezo,
                       input int lat, input bit push);
    exp_t e;
    int   n;
    sel = sl; r = rr; s = ss; ci = c; use_carry = uc; norm_en = ne; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%b, expected 1 within 50 cycles", in_ready);
    end else if (push) begin
      e.f = ef; e.cnt = ecnt; e.co = eco; e.vo = evo; e.no = eno; e.zo = ezo;
      e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    r = 10'($urandom); s = 10'($urandom); sel = 2'($urandom);
    ci = 1'($urandom); use_carry = 1'($urandom); norm_en = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d, expected 0", q.size());
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    r = '0; s = '0; ci = 1'b0; use_carry = 1'b0; sel = '0; norm_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, f, shift_cnt, co, vo, no, zo} !== {1'b1, 1'b0, 18'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b f=%b cnt=%0d flags=%b%b%b%b, expected rdy=1 vld=0 all zero",
               in_ready, out_valid, f, shift_cnt, co, vo, no, zo);
    end
    rst = 1'b0;

    //     sel    R              S              ci    uc    ne    f              cnt co vo no zo lat
    issue(2'b00, 10'b1100110011, 10'b1010101010, 1'b0, 1'b0, 1'b0, 10'b1011101110, 4'd0, 0, 0, 1, 0, 2, 1);
    issue(2'b00, 10'b1100110011, 10'b1010101010, 1'b0, 1'b0, 1'b1, 10'b1011101110, 4'd0, 0, 0, 1, 0, 2, 1);
    issue(2'b01, 10'b0000001111, 10'b0000000001, 1'b1, 1'b0, 1'b1, 10'b0100010000, 4'd4, 0, 0, 0, 0, 6, 1);
    issue(2'b10, 10'b1111000011, 10'b1010101010, 1'b0, 1'b0, 1'b0, 10'b1010010110, 4'd0, 0, 0, 1, 0, 2, 1);
    issue(2'b11, 10'b1000000000, 10'b0000001111, 1'b1, 1'b0, 1'b0, 10'b0111110001, 4'd0, 1, 1, 0, 0, 2, 1);
    issue(2'b01, 10'b1111111111, 10'b0000000001, 1'b0, 1'b0, 1'b1, 10'b0000000000, 4'd0, 1, 0, 0, 1, 2, 1);
    issue(2'b01, 10'b0000000000, 10'b0000000000, 1'b0, 1'b1, 1'b0, 10'b0000000001, 4'd0, 0, 0, 0, 0, 2, 1);
    drain();

    // Max shift under backpressure: result must hold for 5 cycles.
    out_ready = 1'b0;
    issue(2'b00, 10'b0000000000, 10'b0000000000, 1'b0, 1'b0, 1'b1, 10'b1000000000, 4'd9, 0, 0, 1, 0, 11, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout out_valid=%b, expected 1 within 40 cycles", out_valid);
    end
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    drain();

    // Load carry_q=1, then reset mid-NORM; the following use_carry add must see 0.
    issue(2'b01, 10'b1111111111, 10'b0000000010, 1'b0, 1'b0, 1'b1, 10'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_norm got rdy=%b vld=%b, expected rdy=0 vld=0", in_ready, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, f, shift_cnt, co, vo, no, zo} !== {1'b1, 1'b0, 18'b0}) begin
      errors++;
      $display("FAIL reset_norm got rdy=%b vld=%b f=%b cnt=%0d flags=%b%b%b%b, expected rdy=1 vld=0 all zero",
               in_ready, out_valid, f, shift_cnt, co, vo, no, zo);
    end
    issue(2'b01, 10'b0000000000, 10'b0000000000, 1'b1, 1'b1, 1'b0, 10'b0000000000, 4'd0, 0, 0, 0, 1, 2, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
